// File: rtl/edram_sched.sv
// Slot scheduler and refresh controller for the 32-row eDRAM macro.
// Each 4-clk slot carries one access or refresh; its writeback lands in the slot's last clk.
module edram_sched #(
   parameter int ROWS         = 32,
   parameter int ADDR_W       = 5,
   parameter int REF_INTERVAL = 256,
   parameter int REF_URGENT   = 2,
   parameter int OWED_W       = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              macro_en,
   output logic              macro_ref,
   output logic [ADDR_W-1:0] macro_addr,
   output logic              macro_wen,
   output logic [ADDR_W-1:0] macro_waddr,
   output logic              macro_wdata_sel,
   output logic              rd_done,
   output logic [ADDR_W-1:0] ref_row,
   output logic [OWED_W-1:0] ref_owed,
   output logic              ref_overflow
);

   localparam int TIMER_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
   localparam logic [OWED_W-1:0] OWED_MAX = '1;

   typedef enum logic [1:0] {SLOT_IDLE, SLOT_ACCESS, SLOT_REFRESH} slot_t;

   slot_t              state;
   slot_t              next_state;
   logic [1:0]         phase;
   logic [TIMER_W-1:0] timer;
   logic               credit;
   logic               urgent;
   logic               issue_acc;
   logic               issue_ref;
   logic               wb;
   logic [ADDR_W-1:0]  lat_addr;
   logic               lat_write;

   assign credit = (timer == TIMER_W'(REF_INTERVAL - 1));
   assign urgent = (int'(ref_owed) >= REF_URGENT);

   always_ff @(posedge clk) begin
      if (rst) state <= SLOT_IDLE;
      else     state <= next_state;
   end

   // Slot arbitration happens only at phase 0; an urgent refresh backlog beats a waiting requester.
   always_comb begin
      issue_acc  = 1'b0;
      issue_ref  = 1'b0;
      next_state = state;
      if (!rst && phase == 2'd0) begin
         issue_acc = !urgent && req_valid;
         issue_ref = urgent || (!req_valid && ref_owed != '0);
      end
      if (issue_acc)                              next_state = SLOT_ACCESS;
      else if (issue_ref)                         next_state = SLOT_REFRESH;
      else if (phase == 2'd3 || phase == 2'd0)    next_state = SLOT_IDLE;
   end

   always_comb begin
      req_ready       = issue_acc;
      macro_en        = issue_acc;
      macro_ref       = issue_ref;
      macro_addr      = '0;
      if (issue_acc)      macro_addr = req_addr;
      else if (issue_ref) macro_addr = ref_row;
      wb              = !rst && phase == 2'd3 && state != SLOT_IDLE;
      macro_wen       = wb;
      macro_waddr     = wb ? lat_addr : '0;
      macro_wdata_sel = wb && state == SLOT_ACCESS && lat_write;
      rd_done         = wb && state == SLOT_ACCESS && !lat_write;
   end

   // A credit landing on the same clk as a refresh issue cancels out; only a lost credit flags overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase        <= '0;
         timer        <= '0;
         ref_owed     <= '0;
         ref_row      <= '0;
         ref_overflow <= 1'b0;
         lat_addr     <= '0;
         lat_write    <= 1'b0;
      end else begin
         phase <= phase + 2'd1;
         timer <= credit ? '0 : timer + 1'b1;
         if (issue_acc) begin
            lat_addr  <= req_addr;
            lat_write <= req_write;
         end else if (issue_ref) begin
            lat_addr  <= ref_row;
            lat_write <= 1'b0;
            ref_row   <= (ref_row == ADDR_W'(ROWS - 1)) ? '0 : ref_row + 1'b1;
         end
         if (credit && !issue_ref) begin
            if (ref_owed == OWED_MAX) ref_overflow <= 1'b1;
            else                      ref_owed     <= ref_owed + 1'b1;
         end else if (!credit && issue_ref) begin
            ref_owed <= ref_owed - 1'b1;
         end
      end
   end

endmodule
